// File: rtl/cdb_arbiter_if.sv
// Bus between the result producers and the CDB arbiter: requests, grants and the registered broadcast.
interface cdb_arbiter_if #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int LS_IDX_W = 3
);
    logic                  flush;
    logic                  cdb_stall;
    logic [5:0]            req;
    logic [6*DATA_W-1:0]   req_data;
    logic [LS_IDX_W-1:0]   ls_idx;
    logic [5:0]            gnt;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [DATA_W-1:0]     cdb_data;
    logic [2:0]            rr_ptr;

    modport master (
        output flush, cdb_stall, req, req_data, ls_idx,
        input  gnt, cdb_valid, cdb_tag, cdb_data, rr_ptr
    );

    modport slave (
        input  flush, cdb_stall, req, req_data, ls_idx,
        output gnt, cdb_valid, cdb_tag, cdb_data, rr_ptr
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus with a one-cycle registered broadcast.
// Optional macro CDB_LS_PRIO_EN: load/store wins outright and the other five round-robin.
module cdb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int LS_IDX_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);
    localparam int LS = 5;

    logic             any;
    logic [2:0]       win;
    logic [2:0]       ptr_nxt;
    logic             hold;
    logic [5:0]       gnt_c;
    logic [TAG_W-1:0] tag_c;
    int               idx;

    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
`ifdef CDB_LS_PRIO_EN
        if (bus.req[LS]) begin
            any = 1'b1;
            win = 3'(LS);
        end else begin
            for (int k = 0; k < 5; k++) begin
                idx = int'(bus.rr_ptr) + k;
                if (idx >= 5) idx = idx - 5;
                if (!any && bus.req[idx]) begin
                    any = 1'b1;
                    win = 3'(idx);
                end
            end
        end
`else
        for (int k = 0; k < 6; k++) begin
            idx = int'(bus.rr_ptr) + k;
            if (idx >= 6) idx = idx - 6;
            if (!any && bus.req[idx]) begin
                any = 1'b1;
                win = 3'(idx);
            end
        end
`endif
    end

    // LS tags live in the upper half of the tag space, one per queue entry.
    always_comb begin
        tag_c = TAG_W'(int'(win) + 1);
        if (win == 3'(LS)) tag_c = TAG_W'(8 + int'(bus.ls_idx));
    end

    always_comb begin
        ptr_nxt = win + 3'd1;
`ifdef CDB_LS_PRIO_EN
        if (win == 3'(LS)) ptr_nxt = bus.rr_ptr;
        else if (win == 3'd4) ptr_nxt = 3'd0;
`else
        if (win == 3'(LS)) ptr_nxt = 3'd0;
`endif
    end

    // Grant is combinational, so reset must gate it as well as the registers.
    assign hold  = !rst_n || bus.flush || bus.cdb_stall;
    assign gnt_c = (any && !hold) ? (6'b000001 << win) : 6'b000000;
    assign bus.gnt = gnt_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.rr_ptr    <= '0;
        end else if (bus.flush) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.rr_ptr    <= '0;
        end else if (bus.cdb_stall) begin
            bus.cdb_valid <= 1'b0;
        end else if (any) begin
            bus.cdb_valid <= 1'b1;
            bus.cdb_tag   <= tag_c;
            bus.cdb_data  <= bus.req_data[int'(win)*DATA_W +: DATA_W];
            bus.rr_ptr    <= ptr_nxt;
        end else begin
            bus.cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized handshake run against a rule-based model.
module tb_cdb_arbiter;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int LS_IDX_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LS_IDX_W(LS_IDX_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LS_IDX_W(LS_IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int               m_ptr;
    bit               m_valid;
    logic [TAG_W-1:0] m_tag;
    logic [DATA_W-1:0] m_data;

    // Observations from the last tick
    logic [5:0]        obs_gnt, exp_gnt;
    logic              obs_valid;
    logic [TAG_W-1:0]  obs_tag;
    logic [DATA_W-1:0] obs_data;
    logic [2:0]        obs_ptr;

    // Priority order is the list of producers starting at the pointer; first requester in it wins.
    function automatic int pick(logic [5:0] r, int ptr);
        int order[$];
`ifdef CDB_LS_PRIO_EN
        if (r[5]) return 5;
        for (int s = 0; s < 5; s++) order.push_back((ptr + s) % 5);
`else
        for (int s = 0; s < 6; s++) order.push_back((ptr + s) % 6);
`endif
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [5:0] model_gnt();
        int w;
        w = pick(bus.req, m_ptr);
        if (!rst_n || bus.flush || bus.cdb_stall || w < 0) return 6'b0;
        return 6'b1 << w;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0;
    endtask

    task automatic model_edge();
        int w;
        w = pick(bus.req, m_ptr);
        if (bus.flush) begin
            m_valid = 0; m_tag = '0; m_ptr = 0;
        end else if (bus.cdb_stall || w < 0) begin
            m_valid = 0;
        end else begin
            m_valid = 1;
            m_tag   = (w == 5) ? TAG_W'(8 + int'(bus.ls_idx)) : TAG_W'(w + 1);
            m_data  = bus.req_data[w*DATA_W +: DATA_W];
`ifdef CDB_LS_PRIO_EN
            if (w != 5) m_ptr = (w + 1) % 5;
`else
            m_ptr = (w + 1) % 6;
`endif
        end
    endtask

    // One clock: grant sampled mid-low phase, model advanced at the edge, registers sampled 1ns later.
    task automatic tick();
        @(negedge clk);
        obs_gnt = bus.gnt;
        exp_gnt = model_gnt();
        @(posedge clk);
        model_edge();
        #1;
        obs_valid = bus.cdb_valid; obs_tag = bus.cdb_tag;
        obs_data  = bus.cdb_data;  obs_ptr = bus.rr_ptr;
    endtask

    task automatic set_data(int i, logic [DATA_W-1:0] d);
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        bus.flush = 0; bus.cdb_stall = 0; bus.req = 6'b111111;
        bus.req_data = '0; bus.ls_idx = '0;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({bus.gnt, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rr_ptr} !== '0) begin
            miscompares++;
            $display("FAIL reset gnt=%b v=%b tag=%0d data=%h ptr=%0d want all zero",
                     bus.gnt, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rr_ptr);
        end
        bus.req = 6'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        @(posedge clk); model_edge(); #1;
    endtask

    task automatic test_single();
        bus.req = 6'b000001; set_data(0, 32'h11);
        tick();
        vectors++;
        if (obs_gnt !== exp_gnt || obs_gnt !== 6'b000001) begin
            miscompares++; $display("FAIL single_gnt got %b want %b", obs_gnt, exp_gnt);
        end
        vectors++;
        if ({obs_valid, obs_tag, obs_data, obs_ptr} !== {1'b1, 4'd1, 32'h11, 3'd1}) begin
            miscompares++;
            $display("FAIL single_bcast got v=%b tag=%0d data=%h ptr=%0d want v=1 tag=1 data=11 ptr=1",
                     obs_valid, obs_tag, obs_data, obs_ptr);
        end
        bus.req = 6'b0;
        tick();
    endtask

    task automatic test_all_req();
        // Walk the pointer back to 0 first: index 5 alone wraps it.
        bus.req = 6'b100000; tick(); bus.req = 6'b0;
        bus.ls_idx = 3'(($urandom % 8));
        for (int i = 0; i < 6; i++) set_data(i, $urandom);
        bus.req = 6'b111111;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (obs_gnt !== exp_gnt || obs_gnt !== (6'b1 << c)) begin
                miscompares++; $display("FAIL all_req_gnt c=%0d got %b want %b", c, obs_gnt, exp_gnt);
            end
            vectors++;
            if ({obs_valid, obs_tag, obs_data, obs_ptr} !== {m_valid, m_tag, m_data, 3'(m_ptr)}) begin
                miscompares++;
                $display("FAIL all_req_bcast c=%0d got v=%b tag=%0d data=%h ptr=%0d want v=%b tag=%0d data=%h ptr=%0d",
                         c, obs_valid, obs_tag, obs_data, obs_ptr, m_valid, m_tag, m_data, m_ptr);
            end
        end
        bus.req = 6'b0;
        tick();
    endtask

    task automatic test_wrap();
        bus.req = 6'b010000; set_data(4, 32'h44); tick();
        bus.req = 6'b100001; bus.ls_idx = 3'd3;
        set_data(5, 32'h55); set_data(0, 32'h10);
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (obs_gnt !== exp_gnt) begin
                miscompares++; $display("FAIL wrap_gnt c=%0d got %b want %b", c, obs_gnt, exp_gnt);
            end
            vectors++;
            if ({obs_valid, obs_tag, obs_data, obs_ptr} !== {m_valid, m_tag, m_data, 3'(m_ptr)}) begin
                miscompares++;
                $display("FAIL wrap_bcast c=%0d got v=%b tag=%0d ptr=%0d want v=%b tag=%0d ptr=%0d",
                         c, obs_valid, obs_tag, obs_ptr, m_valid, m_tag, m_ptr);
            end
            bus.req = bus.req & ~obs_gnt;
        end
        bus.req = 6'b0;
        tick();
    endtask

    task automatic test_stall();
        bus.req = 6'b000100; set_data(2, 32'hCAFE); bus.cdb_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.cdb_stall = 1'b0;
            tick();
            vectors++;
            if (obs_gnt !== exp_gnt || obs_valid !== m_valid || obs_ptr !== 3'(m_ptr)) begin
                miscompares++;
                $display("FAIL stall c=%0d got gnt=%b v=%b ptr=%0d want gnt=%b v=%b ptr=%0d",
                         c, obs_gnt, obs_valid, obs_ptr, exp_gnt, m_valid, m_ptr);
            end
        end
        vectors++;
        if (obs_tag !== 4'd3 || obs_valid !== 1'b1) begin
            miscompares++; $display("FAIL stall_release tag got %0d want 3", obs_tag);
        end
        bus.req = 6'b0;
        tick();
    endtask

    task automatic test_flush_and_reset();
        bus.req = 6'b001000; set_data(3, 32'hBEEF); tick();
        bus.req = 6'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        vectors++;
        if ({obs_gnt, obs_valid, obs_tag, obs_ptr} !== {exp_gnt, m_valid, m_tag, 3'(m_ptr)} ||
            obs_ptr !== 3'd0 || obs_tag !== '0) begin
            miscompares++;
            $display("FAIL flush got gnt=%b v=%b tag=%0d ptr=%0d want gnt=0 v=0 tag=0 ptr=0",
                     obs_gnt, obs_valid, obs_tag, obs_ptr);
        end
        bus.req = 6'b111111;
        tick();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.gnt, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rr_ptr} !== '0) begin
            miscompares++;
            $display("FAIL async_reset gnt=%b v=%b tag=%0d data=%h ptr=%0d want all zero",
                     bus.gnt, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rr_ptr);
        end
        model_reset();
        bus.req = 6'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); model_edge(); #1;
    endtask

`ifdef CDB_LS_PRIO_EN
    task automatic test_ls_prio();
        bus.req = 6'b100011; bus.ls_idx = 3'd2;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) bus.req = 6'b000011;
            tick();
            vectors++;
            if (obs_gnt !== exp_gnt || {obs_valid, obs_tag, obs_ptr} !== {m_valid, m_tag, 3'(m_ptr)}) begin
                miscompares++;
                $display("FAIL ls_prio c=%0d got gnt=%b tag=%0d ptr=%0d want gnt=%b tag=%0d ptr=%0d",
                         c, obs_gnt, obs_tag, obs_ptr, exp_gnt, m_tag, m_ptr);
            end
            if (c >= 4) bus.req = bus.req & ~obs_gnt;
        end
        bus.req = 6'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        int   age[6];
        logic [5:0] pend;
        foreach (age[i]) age[i] = 0;
        for (int c = 0; c < 400; c++) begin
            bus.flush     = ($urandom % 32) == 0;
            bus.cdb_stall = ($urandom % 8) == 0;
            for (int i = 0; i < 6; i++) begin
                if (!bus.req[i] && ($urandom % 3) == 0) begin
                    bus.req[i] = 1'b1;
                    set_data(i, $urandom);
                    if (i == 5) bus.ls_idx = 3'($urandom % 8);
                end
            end
            pend = bus.req;
            tick();
            vectors++;
            if (obs_gnt !== exp_gnt) begin
                miscompares++; $display("FAIL random_gnt c=%0d got %b want %b", c, obs_gnt, exp_gnt);
            end
            vectors++;
            if ({obs_valid, obs_tag, obs_ptr} !== {m_valid, m_tag, 3'(m_ptr)} || obs_data !== m_data) begin
                miscompares++;
                $display("FAIL random_bcast c=%0d got v=%b tag=%0d data=%h ptr=%0d want v=%b tag=%0d data=%h ptr=%0d",
                         c, obs_valid, obs_tag, obs_data, obs_ptr, m_valid, m_tag, m_data, m_ptr);
            end
`ifndef CDB_LS_PRIO_EN
            for (int i = 0; i < 6; i++) begin
                if (bus.flush || obs_gnt[i] || !pend[i]) age[i] = 0;
                else if (!bus.cdb_stall) age[i]++;
                vectors++;
                if (age[i] > 5) begin
                    miscompares++; $display("FAIL starvation c=%0d req=%0d waited %0d want <=5", c, i, age[i]);
                    age[i] = 0;
                end
            end
`endif
            bus.req = bus.req & ~obs_gnt;
        end
        bus.flush = 1'b0; bus.cdb_stall = 1'b0; bus.req = 6'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_wrap();
        test_stall();
        test_flush_and_reset();
`ifdef CDB_LS_PRIO_EN
        test_ls_prio();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
